// File: rtl/rgb_window_builder.sv
// Sliding 3x3 RGB window generator over a raster pixel stream, two line buffers deep.
// Optional WINDOW_COORD_EN adds out_row/out_col giving the window centre.
module rgb_window_builder #(
  parameter int BIT_PER_PIXEL = 8,
  parameter int IMG_WIDTH     = 64,
  parameter int IMG_HEIGHT    = 48
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [BIT_PER_PIXEL-1:0]     in_red,
  input  logic [BIT_PER_PIXEL-1:0]     in_green,
  input  logic [BIT_PER_PIXEL-1:0]     in_blue,
  output logic                         out_valid,
  output logic [27*BIT_PER_PIXEL-1:0]  window_out,
`ifdef WINDOW_COORD_EN
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
`endif
  output logic                         frame_done
);

  localparam int PW = 3 * BIT_PER_PIXEL;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]   col_q, col_d, cur_col;
  logic [RW-1:0]   row_q, row_d, cur_row;
  logic            col_last, row_last;
  logic [PW-1:0]   pix;
  logic [PW-1:0]   lb0 [IMG_WIDTH];
  logic [PW-1:0]   lb1 [IMG_WIDTH];
  logic [PW-1:0]   win_q [9];
  logic [PW-1:0]   win_d [9];
  logic [9*PW-1:0] window_q, window_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_done_q, frame_done_d;
`ifdef WINDOW_COORD_EN
  logic [RW-1:0]   out_row_q, out_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;
`endif

  always_comb begin
    pix      = {in_red, in_green, in_blue};
    // A qualified sof forces this pixel to (0,0) whatever the counters say.
    cur_col  = in_sof ? '0 : col_q;
    cur_row  = in_sof ? '0 : row_q;
    col_last = (cur_col == CW'(IMG_WIDTH - 1));
    row_last = (cur_row == RW'(IMG_HEIGHT - 1));

    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    window_d     = window_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef WINDOW_COORD_EN
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
`endif

    if (in_valid) begin
      col_d = col_last ? '0 : cur_col + CW'(1);
      row_d = col_last ? (row_last ? '0 : cur_row + RW'(1)) : cur_row;

      for (int unsigned r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2] = lb1[cur_col];
      win_d[5] = lb0[cur_col];
      win_d[8] = pix;

      if (cur_col >= CW'(2) && cur_row >= RW'(2)) begin
        out_valid_d = 1'b1;
        for (int unsigned k = 0; k < 9; k++) begin
          window_d[k*PW +: PW] = win_d[k];
        end
`ifdef WINDOW_COORD_EN
        out_row_d = cur_row - RW'(1);
        out_col_d = cur_col - CW'(1);
`endif
      end
      frame_done_d = col_last && row_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      window_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
`ifdef WINDOW_COORD_EN
      out_row_q    <= '0;
      out_col_q    <= '0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      window_q     <= window_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
`ifdef WINDOW_COORD_EN
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
`endif
    end
  end

  // Line buffers are plain RAM: no reset, read-before-write on the same address.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= pix;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign window_out = window_q;
`ifdef WINDOW_COORD_EN
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
`endif

endmodule

// File: tb/tb_rgb_window_builder.sv
// Scoreboard bench for rgb_window_builder on an 8x6 image; expected windows come from the pixel formula.
module tb_rgb_window_builder;

  localparam int W = 8;
  localparam int H = 6;
  localparam int BPP = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [BPP-1:0] in_red = '0, in_green = '0, in_blue = '0;
  logic out_valid, frame_done;
  logic [27*BPP-1:0] window_out;
`ifdef WINDOW_COORD_EN
  logic [2:0] out_row, out_col;
`endif

  rgb_window_builder #(.BIT_PER_PIXEL(BPP), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .out_valid(out_valid), .window_out(window_out),
`ifdef WINDOW_COORD_EN
    .out_row(out_row), .out_col(out_col),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ov;
    bit          fd;
    bit          cw;
    logic [215:0] win;
    logic [2:0]  r;
    logic [2:0]  c;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ov_count = 0;
  int   fd_count = 0;
  bit   mon_en = 1'b0;

  function automatic exp_t zero_exp(bit check_win);
    exp_t e;
    e.ov = 1'b0; e.fd = 1'b0; e.cw = check_win; e.win = '0; e.r = '0; e.c = '0;
    return e;
  endfunction

  function automatic exp_t mk_win(int r, int c, int off, bit fd);
    exp_t e;
    int p;
    logic [7:0] rr, gg, bb;
    e = zero_exp(1'b1);
    e.ov = 1'b1; e.fd = fd;
    e.r = 3'(r - 1); e.c = 3'(c - 1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p  = (r - 2 + i) * W + (c - 2 + j) + off;
        rr = 8'(p); gg = 8'(p + 64); bb = 8'(255 - p);
        e.win[(3*i + j)*24 +: 24] = {rr, gg, bb};
      end
    end
    return e;
  endfunction

  // Scoreboard: one expected entry per driven cycle, popped 1ns after the edge that consumed it.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) ov_count++;
    if (frame_done === 1'b1) fd_count++;
    if (q.size() > 0) begin
      me = q.pop_front();
      n_checks++;
      if (out_valid !== me.ov) $display("FAIL out_valid got %b want %b t=%0t", out_valid, me.ov, $time);
      else n_pass++;
      n_checks++;
      if (frame_done !== me.fd) $display("FAIL frame_done got %b want %b t=%0t", frame_done, me.fd, $time);
      else n_pass++;
      if (me.ov || me.cw) begin
        n_checks++;
        if (window_out !== me.win) $display("FAIL window_out got %h want %h t=%0t", window_out, me.win, $time);
        else n_pass++;
`ifdef WINDOW_COORD_EN
        n_checks++;
        if (out_row !== me.r || out_col !== me.c)
          $display("FAIL coord got %0d,%0d want %0d,%0d t=%0t", out_row, out_col, me.r, me.c, $time);
        else n_pass++;
`endif
      end
    end else if (mon_en) begin
      n_checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0)
        $display("FAIL idle_outputs got ov=%b fd=%b want 0,0 t=%0t", out_valid, frame_done, $time);
      else n_pass++;
    end
  end

  task automatic step(input bit rst, input bit v, input bit s,
                      input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input exp_t e);
    @(posedge clk);
    #2;
    reset = rst; in_valid = v; in_sof = s;
    in_red = rr; in_green = gg; in_blue = bb;
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, zero_exp(1'b0));
  endtask

  task automatic drain();
    idle();
    idle();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int off, input bit gaps, input int npix, input bit use_sof);
    int r, c, p;
    exp_t e;
    for (int idx = 0; idx < npix; idx++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle();
      r = idx / W; c = idx % W; p = idx + off;
      e = (r >= 2 && c >= 2) ? mk_win(r, c, off, idx == W*H - 1) : zero_exp(1'b0);
      step(1'b0, 1'b1, use_sof && idx == 0, 8'(p), 8'(p + 64), 8'(255 - p), e);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, zero_exp(1'b1));
    mon_en = 1'b1;
    drain();
  endtask

  task automatic test_frame();
    int b_ov, b_fd;
    b_ov = ov_count; b_fd = fd_count;
    send_frame(0, 1'b0, W*H, 1'b1);
    drain();
    n_checks++;
    if (ov_count - b_ov !== 24) $display("FAIL frame_windows got %0d want 24", ov_count - b_ov);
    else n_pass++;
    n_checks++;
    if (fd_count - b_fd !== 1) $display("FAIL frame_done_count got %0d want 1", fd_count - b_fd);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int b_ov;
    b_ov = ov_count;
    send_frame(0, 1'b1, W*H, 1'b1);
    drain();
    n_checks++;
    if (ov_count - b_ov !== 24) $display("FAIL gap_windows got %0d want 24", ov_count - b_ov);
    else n_pass++;
  endtask

  task automatic test_mid_sof();
    int b_ov, b_fd;
    b_fd = fd_count;
    send_frame(0, 1'b0, 20, 1'b1);
    drain();
    b_ov = ov_count;
    send_frame(100, 1'b0, W*H, 1'b1);
    drain();
    n_checks++;
    if (ov_count - b_ov !== 24) $display("FAIL sof_windows got %0d want 24", ov_count - b_ov);
    else n_pass++;
    n_checks++;
    if (fd_count - b_fd !== 1) $display("FAIL sof_frame_done got %0d want 1", fd_count - b_fd);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int b_ov;
    send_frame(0, 1'b0, 13, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, zero_exp(1'b1));
    drain();
    b_ov = ov_count;
    send_frame(0, 1'b0, W*H, 1'b0);
    drain();
    n_checks++;
    if (ov_count - b_ov !== 24) $display("FAIL reset_windows got %0d want 24", ov_count - b_ov);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int b_ov, b_fd;
    b_ov = ov_count; b_fd = fd_count;
    send_frame(0, 1'b0, W*H, 1'b1);
    send_frame(0, 1'b0, W*H, 1'b0);
    drain();
    n_checks++;
    if (ov_count - b_ov !== 48) $display("FAIL b2b_windows got %0d want 48", ov_count - b_ov);
    else n_pass++;
    n_checks++;
    if (fd_count - b_fd !== 2) $display("FAIL b2b_frame_done got %0d want 2", fd_count - b_fd);
    else n_pass++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_frame();
    test_gaps();
    test_mid_sof();
    test_mid_reset();
    test_back_to_back();
    n_checks++;
    if (q.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_window_builder.md
Name: rgb_window_builder

Overview:
Converts a raster-order RGB pixel stream into sliding 3x3 RGB windows for the grayscale converter stage directly downstream.
- Two on-chip line buffers hold the previous two image rows.
- A 3x3 shift-register window presents one complete neighbourhood per accepted pixel, once the window lies fully inside the image.
- Output packing matches the downstream 9-pixel RGB input (pixel 0..8).

Parameters:
BIT_PER_PIXEL, 8, width of each colour component
IMG_WIDTH, 64, pixels per row (>= 3)
IMG_HEIGHT, 48, rows per frame (>= 3)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  pixel present this cycle; no backpressure, every valid pixel is accepted
in_sof  input  1  start of frame; qualified by in_valid, marks pixel (row 0, col 0)
in_red  input  BIT_PER_PIXEL  red component
in_green  input  BIT_PER_PIXEL  green component
in_blue  input  BIT_PER_PIXEL  blue component
out_valid  output  1  window_out holds a new complete window (1-cycle pulse)
window_out  output  27*BIT_PER_PIXEL  packed 3x3 RGB window (see Behaviour)
frame_done  output  1  1-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset: out_valid=0, frame_done=0, window_out=0, row/col counters=0, window registers=0. Line-buffer RAM is not reset; its contents are don't-care until rewritten.
- Counters: col runs 0..IMG_WIDTH-1. On wrap, row increments over 0..IMG_HEIGHT-1. Both advance only on in_valid.
- Accepted pixel at column col:
  - New right window column is top=lb1[col], mid=lb0[col], bottom=incoming pixel.
  - Existing window columns shift left by one.
  - Then lb1[col] <= lb0[col] and lb0[col] <= incoming pixel.
  - Line-buffer read and write of the same address occur in the same cycle; the read returns the old value.
- Output condition: out_valid=1 the cycle after a pixel is accepted with col>=2 and row>=2, so latency is 1 cycle.
  - The window then covers rows row-2..row and columns col-2..col.
  - No windows are emitted across a row wrap or frame edge.
  - Each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- window_out packing:
  - Pixel k sits at bits [(k+1)*3*BPP-1 : k*3*BPP], k = 3*r + c, r/c = 0..2, k=0 top-left, k=8 bottom-right.
  - Within a pixel the order is {red, green, blue}, red in the MSBs.
- window_out holds its value when out_valid=0.
- Last pixel (col=IMG_WIDTH-1, row=IMG_HEIGHT-1) accepted:
  - Next cycle frame_done=1, coinciding with that window's out_valid=1.
  - Counters return to 0.
- in_sof with in_valid:
  - The pixel is forced to (0,0) regardless of counter state, and the counters restart.
  - A mid-frame sof aborts the frame: no frame_done for the aborted frame.
  - Stale line-buffer data is never emitted, because row<2 gates output.
- in_sof without in_valid: ignored.
- in_valid=0: no state change; out_valid and frame_done are 0 the next cycle.
- Reset mid-frame: discards position; the next frame begins at the next in_sof or at (0,0).

Optional Feature:
WINDOW_COORD_EN
- Defined: adds output ports out_row and out_col, widths $clog2(IMG_HEIGHT) and $clog2(IMG_WIDTH).
  - They give the window centre (row-1, col-1), registered alongside window_out.
  - Reset value 0; they hold when out_valid=0.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6; pixel p=row*8+col with R=p, G=p+64, B=255-p, fed continuously after sof:
  - First out_valid occurs 1 cycle after pixel p=18.
  - Window pixel0 R=0, pixel4 R=9, pixel8 R=18, pixel8 G=82, pixel8 B=237.
- Same frame: count out_valid pulses = 24.
  - No out_valid after any col=0 or col=1 pixel.
  - frame_done pulses once, coincident with the window whose pixel8 R=47.
- Random in_valid gaps (about 50% duty) with the same frame: identical sequence of 24 windows; out_valid never asserts in a cycle following in_valid=0.
- Mid-frame sof:
  - After 20 pixels, assert sof and stream a full new frame with p offset by 100.
  - No frame_done for the aborted frame.
  - First window after restart has pixel0 R=100.
  - Exactly 24 windows follow.
- Reset asserted mid-frame for 1 cycle:
  - Next cycle out_valid=0, frame_done=0, window_out=0.
  - A subsequent full frame reproduces the scenario 1 values.
- WINDOW_COORD_EN defined: the first window reports out_row=1, out_col=1; the last reports out_row=4, out_col=6.
